serial_tx_gen: RTL and testbench
================================

SERIAL_TX_GEN -- requirements
Module: serial_tx_gen

Interface
REQ-001 Parameter N, default 8, number of data bits per frame (legal 5..16).
REQ-002 Parameter K, default 4, clock cycles per bit time (legal K >= 2).
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP, default 1, number of stop bits (legal 1 or 2).
REQ-005 clock  input  1  single system clock; all state changes on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  N  parallel word to transmit, sampled only at acceptance.
REQ-008 dav_  input  1  active-low data-valid from producer.
REQ-009 rfd  output  1  ready-for-data to producer, high = may assert dav_.
REQ-010 txd  output  1  serial line, marking (1) when idle.
REQ-011 busy  output  1  high from acceptance until the last stop bit completes.

Function
REQ-012 Frame = start bit 0, N data bits LSB first, parity bit (if PARITY != 0), STOP stop bits of 1; F = 1 + N + (PARITY != 0) + STOP bits.
REQ-013 Even parity: parity bit = XOR of data bits; odd parity: its inverse.
REQ-014 Every frame bit SHALL be driven on txd for exactly K consecutive clock cycles; the line is glitch-free, because txd is registered.
REQ-015 States: IDLE, SHIFT, HOLD; the encoding is internal.
REQ-016 IDLE: rfd=1, txd=1, busy=0; at the edge where dav_=0, capture data_in, then next cycle rfd=0, busy=1, txd=0 (start bit), go to SHIFT.
REQ-017 SHIFT: a bit-time counter (0..K-1) and a bit counter (0..F-1) advance; when the last stop bit's K-th cycle completes, go to HOLD with busy=0, txd=1.
REQ-018 HOLD: rfd=0; go to IDLE at the first edge where dav_=1; if dav_ is already 1 when SHIFT ends, rfd=1 in the first cycle after the last stop bit.
REQ-019 dav_ changes and data_in changes during SHIFT SHALL be ignored; the latched word is transmitted unchanged.
REQ-020 Latency: acceptance edge to start bit on txd = 1 cycle; start bit to txd back at marking after frame = F*K cycles.
REQ-021 Back-to-back: the minimum gap between frames is 1 idle-marking cycle (HOLD->IDLE) plus the producer's dav_ release.
REQ-022 Counter widths: $clog2(K) and $clog2(F) bits; no wrap beyond K-1 or F-1.
REQ-023 Illegal parameter values SHALL stop elaboration with an error message.

Reset
REQ-024 While reset=1 at a posedge: next cycle state=IDLE, rfd=1, txd=1, busy=0, counters=0.
REQ-025 Reset mid-frame aborts the frame immediately (txd=1 the cycle after) and the latched word is discarded.
REQ-026 Reset has priority over dav_ sampled at the same edge.

Structure
REQ-027 Shared include file holds: line levels (marking, start_bit, stop_bit), parity mode codes, state encodings.
REQ-028 One sub-module, tx_bit_timer (parameter K), produces a one-cycle bit_tick at the end of each bit time, with a restart input.
REQ-029 Parity and the frame shift register live in serial_tx_gen; the shift register width is F bits, loaded at acceptance.

Verification
REQ-030 N=8,K=4,PARITY=0,STOP=1, data_in=8'hA5, dav_ low 1 cycle -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total, then rfd=1.
REQ-031 PARITY=1, data 8'h07 -> parity bit 1; PARITY=2, data 8'h00 -> parity bit 1; PARITY=1, data 8'h03 -> parity bit 0.
REQ-032 STOP=2,K=3 -> txd high for 6 cycles after the last data/parity bit before busy falls.
REQ-033 dav_ held low 20 cycles after the frame ends -> rfd stays 0 throughout; rfd=1 one cycle after dav_ rises; no second frame is sent.
REQ-034 reset asserted during data bit 3 -> txd=1, rfd=1, busy=0 next cycle; the following frame 8'h3C transmits correctly.
REQ-035 data_in toggled every cycle during SHIFT -> the transmitted bits match the word captured at acceptance.

Source files
------------

// File: rtl/serial_tx_gen_pkg.sv
// Shared line levels, parity mode codes and FSM state encoding for the serial transmitter.
package serial_tx_gen_pkg;

    localparam logic MARKING   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned MAX_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } tx_state_e;

    // Data is zero-extended by the caller, so unused upper bits do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input int unsigned mode);
        return (^data) ^ logic'(mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-time counter: bit_tick is high for one cycle, during the last cycle of each bit time.
module tx_bit_timer #(
    parameter int unsigned K = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic bit_tick
);

    localparam int unsigned CW = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (!restart && run) begin
            cnt_d = (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Tick is registered from the next count so it lines up with cnt == K-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            bit_tick <= run && !restart && (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/serial_tx_gen.sv
// Parallel-to-serial frame transmitter with dav_/rfd handshake, optional parity and 1-2 stop bits.
module serial_tx_gen
    import serial_tx_gen_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned K      = 4,
    parameter int unsigned PARITY = 0,
    parameter int unsigned STOP   = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         dav_,
    output logic         rfd,
    output logic         txd,
    output logic         busy
);

    localparam int unsigned PW = (PARITY != PAR_NONE) ? 1 : 0;
    localparam int unsigned F  = 1 + N + PW + STOP;
    localparam int unsigned BW = $clog2(F);
    localparam logic [BW-1:0] LAST_BIT = BW'(F - 1);

    if (N < 5 || N > MAX_DATA_W) begin : g_bad_n
        $error("serial_tx_gen: N=%0d is outside 5..16", N);
    end
    if (K < 2) begin : g_bad_k
        $error("serial_tx_gen: K=%0d must be at least 2", K);
    end
    if (PARITY > PAR_ODD) begin : g_bad_parity
        $error("serial_tx_gen: PARITY=%0d must be 0, 1 or 2", PARITY);
    end
    if (STOP < 1 || STOP > 2) begin : g_bad_stop
        $error("serial_tx_gen: STOP=%0d must be 1 or 2", STOP);
    end

    tx_state_e     state;
    tx_state_e     state_d;
    logic [F-1:0]  shreg;
    logic [F-1:0]  shreg_d;
    logic [F-1:0]  frame;
    logic [BW-1:0] bit_idx;
    logic [BW-1:0] bit_idx_d;
    logic          txd_d;
    logic          rfd_d;
    logic          busy_d;
    logic          accept;
    logic          bit_tick;

    tx_bit_timer #(.K(K)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (accept),
        .run      (state == ST_SHIFT),
        .bit_tick (bit_tick)
    );

    // Full frame image, bit 0 first on the line; positions above data/parity are stop bits.
    always_comb begin
        frame      = {F{STOP_BIT}};
        frame[0]   = START_BIT;
        frame[N:1] = data_in;
        if (PARITY != PAR_NONE) begin
            frame[N+1] = parity_bit(MAX_DATA_W'(data_in), PARITY);
        end
    end

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        txd_d     = txd;
        rfd_d     = rfd;
        busy_d    = busy;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!dav_) begin
                    accept    = 1'b1;
                    state_d   = ST_SHIFT;
                    shreg_d   = frame;
                    bit_idx_d = '0;
                    txd_d     = START_BIT;
                    rfd_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_d = '0;
                        txd_d     = MARKING;
                        busy_d    = 1'b0;
                        // A producer that already released dav_ may go again immediately.
                        state_d   = dav_ ? ST_IDLE : ST_HOLD;
                        rfd_d     = dav_;
                    end else begin
                        bit_idx_d = bit_idx + BW'(1);
                        shreg_d   = {STOP_BIT, shreg[F-1:1]};
                        txd_d     = shreg[1];
                    end
                end
            end
            ST_HOLD: begin
                if (dav_) begin
                    state_d = ST_IDLE;
                    rfd_d   = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
                txd_d     = MARKING;
                rfd_d     = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= {F{STOP_BIT}};
            bit_idx <= '0;
            txd     <= MARKING;
            rfd     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_idx <= bit_idx_d;
            txd     <= txd_d;
            rfd     <= rfd_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_gen.sv
// Scoreboard bench for serial_tx_gen across three parameter sets sharing one clock and reset.
module tb_serial_tx_gen;

    localparam int unsigned MAXF = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       dav_a, dav_b, dav_c;
    logic [7:0] data_a, data_b, data_c;
    logic       rfd_a, rfd_b, rfd_c;
    logic       txd_a, txd_b, txd_c;
    logic       busy_a, busy_b, busy_c;

    always #5 clock = ~clock;

    serial_tx_gen #(.N(8), .K(4), .PARITY(0), .STOP(1)) u_a (
        .clock(clock), .reset(reset), .data_in(data_a), .dav_(dav_a),
        .rfd(rfd_a), .txd(txd_a), .busy(busy_a));

    serial_tx_gen #(.N(8), .K(3), .PARITY(1), .STOP(2)) u_b (
        .clock(clock), .reset(reset), .data_in(data_b), .dav_(dav_b),
        .rfd(rfd_b), .txd(txd_b), .busy(busy_b));

    serial_tx_gen #(.N(8), .K(2), .PARITY(2), .STOP(1)) u_c (
        .clock(clock), .reset(reset), .data_in(data_c), .dav_(dav_c),
        .rfd(rfd_c), .txd(txd_c), .busy(busy_c));

    typedef struct {
        logic [MAXF-1:0] bits;
        int unsigned     len;
        int unsigned     k;
        int unsigned     sel;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic int unsigned k_of(input int unsigned sel);
        case (sel)
            0:       return 4;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned par_of(input int unsigned sel);
        return (sel == 0) ? 0 : sel;
    endfunction

    function automatic int unsigned stop_of(input int unsigned sel);
        return (sel == 1) ? 2 : 1;
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, then stop 1s.
    function automatic exp_t model_frame(input int unsigned sel, input logic [7:0] d);
        exp_t e;
        e.sel  = sel;
        e.k    = k_of(sel);
        e.bits = '1;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
        e.len = 9;
        if (par_of(sel) != 0) begin
            e.bits[9] = (^d) ^ (par_of(sel) == 2);
            e.len     = 10;
        end
        e.len = e.len + stop_of(sel);
        return e;
    endfunction

    function automatic logic txd_of(input int unsigned sel);
        case (sel)
            0:       return txd_a;
            1:       return txd_b;
            default: return txd_c;
        endcase
    endfunction

    function automatic logic rfd_of(input int unsigned sel);
        case (sel)
            0:       return rfd_a;
            1:       return rfd_b;
            default: return rfd_c;
        endcase
    endfunction

    function automatic logic busy_of(input int unsigned sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic set_dav(input int unsigned sel, input logic v);
        case (sel)
            0:       dav_a = v;
            1:       dav_b = v;
            default: dav_c = v;
        endcase
    endtask

    task automatic set_data(input int unsigned sel, input logic [7:0] d);
        case (sel)
            0:       data_a = d;
            1:       data_b = d;
            default: data_c = d;
        endcase
    endtask

    // Called at a negedge with the instance idle; returns at the negedge after acceptance.
    task automatic send(input int unsigned sel, input logic [7:0] d, input bit push, input bit hold);
        check_val($sformatf("s%0d_rfd_before_%02h", sel, d), rfd_of(sel), 1'b1);
        set_data(sel, d);
        set_dav(sel, 1'b0);
        if (push) sb_q.push_back(model_frame(sel, d));
        @(negedge clock);
        if (!hold) set_dav(sel, 1'b1);
    endtask

    // Every cycle of every bit is compared; ends one cycle after the last stop bit.
    task automatic check_frame(input bit toggle, input logic rfd_after);
        exp_t        e;
        int unsigned total;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 1'b1, 1'b0);
            return;
        end
        e     = sb_q.pop_front();
        total = e.len * e.k;
        check_val($sformatf("s%0d_busy_start", e.sel), busy_of(e.sel), 1'b1);
        check_val($sformatf("s%0d_rfd_start", e.sel), rfd_of(e.sel), 1'b0);
        for (int unsigned c = 0; c < total; c++) begin
            check_val($sformatf("s%0d_bit%0d_cyc%0d", e.sel, c / e.k, c % e.k),
                      txd_of(e.sel), e.bits[c / e.k]);
            if (toggle) set_data(e.sel, 8'($urandom));
            @(negedge clock);
        end
        check_val($sformatf("s%0d_txd_end", e.sel), txd_of(e.sel), 1'b1);
        check_val($sformatf("s%0d_busy_end", e.sel), busy_of(e.sel), 1'b0);
        check_val($sformatf("s%0d_rfd_end", e.sel), rfd_of(e.sel), rfd_after);
    endtask

    initial begin
        reset = 1'b1;
        dav_a = 1'b1; dav_b = 1'b1; dav_c = 1'b1;
        data_a = '0;  data_b = '0;  data_c = '0;
        repeat (3) @(negedge clock);
        for (int unsigned s = 0; s < 3; s++) begin
            check_val($sformatf("s%0d_reset_rfd", s), rfd_of(s), 1'b1);
            check_val($sformatf("s%0d_reset_txd", s), txd_of(s), 1'b1);
            check_val($sformatf("s%0d_reset_busy", s), busy_of(s), 1'b0);
        end
        reset = 1'b0;
        @(negedge clock);

        // Basic frame, then an immediate second frame with data_in churning.
        send(0, 8'hA5, 1'b1, 1'b0); check_frame(1'b0, 1'b1);
        send(0, 8'h5A, 1'b1, 1'b0); check_frame(1'b1, 1'b1);

        // Even parity, two stop bits, K=3.
        send(1, 8'h07, 1'b1, 1'b0); check_frame(1'b0, 1'b1);
        send(1, 8'h03, 1'b1, 1'b0); check_frame(1'b1, 1'b1);

        // Odd parity, K=2.
        send(2, 8'h00, 1'b1, 1'b0); check_frame(1'b0, 1'b1);
        send(2, 8'hB4, 1'b1, 1'b0); check_frame(1'b0, 1'b1);

        // dav_ held low past the frame: rfd stays low, no repeat frame.
        send(0, 8'hC3, 1'b1, 1'b1); check_frame(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check_val($sformatf("hold_rfd_%0d", i), rfd_a, 1'b0);
            check_val($sformatf("hold_txd_%0d", i), txd_a, 1'b1);
            check_val($sformatf("hold_busy_%0d", i), busy_a, 1'b0);
            @(negedge clock);
        end
        set_dav(0, 1'b1);
        @(negedge clock);
        check_val("hold_release_rfd", rfd_a, 1'b1);
        repeat (3) @(negedge clock);
        check_val("hold_no_second_busy", busy_a, 1'b0);

        // Abort during data bit 3 (frame bit index 4).
        send(0, 8'hFF, 1'b0, 1'b0);
        repeat (4 * 4 + 1) @(negedge clock);
        check_val("abort_pre_busy", busy_a, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check_val("abort_txd", txd_a, 1'b1);
        check_val("abort_rfd", rfd_a, 1'b1);
        check_val("abort_busy", busy_a, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        send(0, 8'h3C, 1'b1, 1'b0); check_frame(1'b0, 1'b1);

        // Reset wins over dav_ at the same edge.
        reset = 1'b1;
        set_dav(0, 1'b0);
        @(negedge clock);
        check_val("prio_busy", busy_a, 1'b0);
        check_val("prio_txd", txd_a, 1'b1);
        check_val("prio_rfd", rfd_a, 1'b1);
        reset = 1'b0;
        set_dav(0, 1'b1);
        @(negedge clock);
        check_val("prio_after_busy", busy_a, 1'b0);

        // Random frames over all three configurations.
        for (int i = 0; i < 6; i++) begin
            int unsigned s;
            s = i % 3;
            send(s, 8'($urandom), 1'b1, 1'b0);
            check_frame(1'b1, 1'b1);
        end

        if (sb_q.size() != 0) check_val("scoreboard_leftover", 1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
